// File: rtl/pixel_arbiter.sv
// ============================================================================
// pixel_arbiter: two-port round-robin front end for the single pixel writer.
// Optional off-screen clipping when PIXEL_ARB_CLIP_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pixel_arbiter #(
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_screen_done,
  input  logic        pixel_wr_done,
  output logic        pixel_en,
  output logic [7:0]  pixel_rgb,
  output logic [7:0]  pixel_x,
  output logic [7:0]  pixel_y,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_rgb,
  input  logic [7:0]  req0_x,
  input  logic [7:0]  req0_y,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_rgb,
  input  logic [7:0]  req1_x,
  input  logic [7:0]  req1_y,
  output logic        busy,
  output logic [15:0] drop_count
);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_next;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       fifo_full;
  logic [1:0]       fifo_empty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       clip;
  logic [1:0][23:0] req_word;
  logic [1:0][23:0] head;

  logic rr_ptr;
  logic grant;
  logic slot_free;
  logic eligible;
  logic load;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_word[0] = {req0_rgb, req0_x, req0_y};
  assign req_word[1] = {req1_rgb, req1_x, req1_y};
  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];

  // Clipped requests complete the handshake but never reach the FIFO.
  assign push = req_valid & req_ready & ~clip;

`ifdef PIXEL_ARB_CLIP_EN
  logic [1:0]  dropped;
  logic [16:0] drop_sum;
  logic [15:0] drop_q;

  assign clip[0]    = (req0_y >= 8'd192);
  assign clip[1]    = (req1_y >= 8'd192);
  assign dropped    = req_valid & req_ready & clip;
  assign drop_sum   = {1'b0, drop_q} + 17'(dropped[0]) + 17'(dropped[1]);
  assign drop_count = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (|dropped) begin
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`else
  assign clip       = 2'b00;
  assign drop_count = 16'd0;
`endif

  for (genvar n = 0; n < 2; n++) begin : g_fifo
    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
      if (push[n]) begin
        mem[wr_ptr] <= req_word[n];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[n]) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop[n]) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        case ({push[n], pop[n]})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end

    assign fifo_full[n]  = (count == FULL_COUNT);
    assign fifo_empty[n] = (count == '0);
    assign head[n]       = mem[rd_ptr];
    // Ready ignores a same-cycle pop so it depends on FIFO state only.
    assign req_ready[n]  = ~fifo_full[n];
  end

  always_comb begin
    slot_free = (state == IDLE) || pixel_wr_done;
    eligible  = clear_screen_done && (fifo_empty != 2'b11);
    load      = slot_free && eligible;
    if (!fifo_empty[0] && !fifo_empty[1]) begin
      grant = rr_ptr;
    end else begin
      grant = fifo_empty[0];
    end
    pop = 2'b00;
    if (load) begin
      pop = grant ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (pixel_wr_done) begin
          state_next = load ? HOLD : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      pixel_rgb <= 8'd0;
      pixel_x   <= 8'd0;
      pixel_y   <= 8'd0;
    end else begin
      state <= state_next;
      if (load) begin
        {pixel_rgb, pixel_x, pixel_y} <= head[grant];
        rr_ptr <= ~grant;
      end
    end
  end

  assign pixel_en = (state == HOLD);
  assign busy     = (fifo_empty != 2'b11) || pixel_en;

endmodule

`default_nettype wire

// File: tb/tb_pixel_arbiter.sv
// ============================================================================
// tb_pixel_arbiter: scoreboard bench for pixel_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pixel_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_screen_done = 1'b0;
  logic        pixel_wr_done = 1'b0;
  logic        pixel_en;
  logic [7:0]  pixel_rgb, pixel_x, pixel_y;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_rgb = '0, req0_x = '0, req0_y = '0;
  logic [7:0]  req1_rgb = '0, req1_x = '0, req1_y = '0;
  logic        busy;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q [$];

  always #5 clk = ~clk;

  pixel_arbiter #(.FIFO_DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst),
    .clear_screen_done(clear_screen_done), .pixel_wr_done(pixel_wr_done),
    .pixel_en(pixel_en), .pixel_rgb(pixel_rgb), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_rgb(req0_rgb), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_rgb(req1_rgb), .req1_x(req1_x), .req1_y(req1_y),
    .busy(busy), .drop_count(drop_count)
  );

  // Every accepted output transfer is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && pixel_en && pixel_wr_done) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h, required none", {pixel_rgb, pixel_x, pixel_y});
      end else begin
        logic [23:0] exp;
        exp = exp_q.pop_front();
        if ({pixel_rgb, pixel_x, pixel_y} !== exp) begin
          n_fail++;
          $display("FAIL output_data: got %h, required %h", {pixel_rgb, pixel_x, pixel_y}, exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit v0, input logic [23:0] d0, input bit v1, input logic [23:0] d1);
    req0_valid = v0;
    {req0_rgb, req0_x, req0_y} = d0;
    req1_valid = v1;
    {req1_rgb, req1_x, req1_y} = d1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_drain(input int budget);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d pixels still pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({pixel_en, pixel_rgb, pixel_x, pixel_y} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", {pixel_en, pixel_rgb, pixel_x, pixel_y});
    end
    n_checks++;
    if ({busy, req0_ready, req1_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL reset_flags: busy/r0/r1 got %b, required 011", {busy, req0_ready, req1_ready});
    end
    n_checks++;
    if (drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_drop_count: got %0d, required 0", drop_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    clear_screen_done = 1'b1;
    pixel_wr_done = 1'b1;
    exp_q.push_back({8'hE0, 8'd50, 8'd50});
    drive(1'b1, {8'hE0, 8'd50, 8'd50}, 1'b0, 24'd0);
    @(negedge clk);
    n_checks++;
    if (pixel_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency_early: pixel_en got %b, required 0", pixel_en);
    end
    @(negedge clk);
    n_checks++;
    if ({pixel_en, pixel_rgb, pixel_x, pixel_y} !== {1'b1, 8'hE0, 8'd50, 8'd50}) begin
      n_fail++;
      $display("FAIL single_output: got %h, required %h",
               {pixel_en, pixel_rgb, pixel_x, pixel_y}, {1'b1, 8'hE0, 8'd50, 8'd50});
    end
    @(negedge clk);
    n_checks++;
    if ({pixel_en, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_idle: pixel_en/busy got %b, required 00", {pixel_en, busy});
    end
  endtask

  task automatic test_contention();
    do_reset();
    clear_screen_done = 1'b0;
    pixel_wr_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({8'h30, 8'(i), 8'd7});
      exp_q.push_back({8'h40, 8'(100 + i), 8'd9});
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {8'h30, 8'(i), 8'd7}, 1'b1, {8'h40, 8'(100 + i), 8'd9});
    end
    clear_screen_done = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (pixel_en !== 1'b1) begin
        n_fail++;
        $display("FAIL contention_consecutive[%0d]: pixel_en got %b, required 1", i, pixel_en);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({pixel_en, busy} !== 2'b00 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL contention_end: pixel_en/busy got %b pending %0d, required 00 and 0",
               {pixel_en, busy}, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    do_reset();
    clear_screen_done = 1'b1;
    pixel_wr_done = 1'b0;
    exp_q.push_back({8'hA5, 8'd11, 8'd22});
    drive(1'b1, {8'hA5, 8'd11, 8'd22}, 1'b0, 24'd0);
    cyc = 0;
    while (pixel_en !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (pixel_en !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_load: pixel_en got %b, required 1", pixel_en);
    end
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        exp_q.push_back({8'(8'h10 + i), 8'(i), 8'h20});
        drive(1'b0, 24'd0, 1'b1, {8'(8'h10 + i), 8'(i), 8'h20});
      end else if (i == 8) begin
        drive(1'b0, 24'd0, 1'b1, 24'hFFFFFF);
      end else begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      n_checks++;
      if ({pixel_en, pixel_rgb, pixel_x, pixel_y} !== {1'b1, 8'hA5, 8'd11, 8'd22}) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: got %h, required %h", i,
                 {pixel_en, pixel_rgb, pixel_x, pixel_y}, {1'b1, 8'hA5, 8'd11, 8'd22});
      end
      n_checks++;
      if (req1_ready !== (i < 7)) begin
        n_fail++;
        $display("FAIL backpressure_ready[%0d]: req1_ready got %b, required %b", i, req1_ready, (i < 7));
      end
    end
    pixel_wr_done = 1'b1;
    wait_drain(40);
    repeat (5) @(negedge clk);
  endtask

  task automatic test_preclear();
    do_reset();
    clear_screen_done = 1'b0;
    pixel_wr_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({8'(8'h60 + i), 8'(200 + i), 8'(5 * i)});
      drive(1'b1, {8'(8'h60 + i), 8'(200 + i), 8'(5 * i)}, 1'b0, 24'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({pixel_en, busy} !== 2'b01) begin
        n_fail++;
        $display("FAIL preclear_block[%0d]: pixel_en/busy got %b, required 01", i, {pixel_en, busy});
      end
    end
    clear_screen_done = 1'b1;
    wait_drain(20);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    clear_screen_done = 1'b0;
    pixel_wr_done = 1'b0;
    drive(1'b1, 24'h010203, 1'b1, 24'h040506);
    drive(1'b1, 24'h070809, 1'b1, 24'h0A0B0C);
    drive(1'b1, 24'h0D0E0F, 1'b0, 24'd0);
    clear_screen_done = 1'b1;
    cyc = 0;
    while (pixel_en !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (pixel_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_load: pixel_en got %b, required 1", pixel_en);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pixel_en, busy, req0_ready, req1_ready} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_mid_state: en/busy/r0/r1 got %b, required 0011",
               {pixel_en, busy, req0_ready, req1_ready});
    end
    pixel_wr_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (pixel_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_silent[%0d]: pixel_en got %b, required 0", i, pixel_en);
      end
    end
  endtask

  task automatic test_clip();
    logic [15:0] exp_drops;
    do_reset();
    clear_screen_done = 1'b1;
    pixel_wr_done = 1'b1;
    exp_q.push_back({8'h1C, 8'd12, 8'd191});
`ifdef PIXEL_ARB_CLIP_EN
    exp_drops = 16'd1;
`else
    exp_q.push_back({8'h3F, 8'd13, 8'd192});
    exp_drops = 16'd0;
`endif
    drive(1'b1, {8'h1C, 8'd12, 8'd191}, 1'b1, {8'h3F, 8'd13, 8'd192});
    wait_drain(10);
    repeat (3) @(negedge clk);
    n_checks++;
    if (drop_count !== exp_drops) begin
      n_fail++;
      $display("FAIL clip_drop_count: got %0d, required %0d", drop_count, exp_drops);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clip_idle: busy got %b, required 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_preclear();
    test_reset_mid();
    test_clip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
